// File: rtl/baud_tick_gen.sv
// ----------------------------------------------------------------------------
// baud_tick_gen
//
// Fractional-N oversample tick generator for a UART-style receiver or
// transmitter. A period counter produces one os_tick per oversample period.
// The period is div + frac/2^F clocks on average: each period lasts
// max(div,1) clocks, plus one extra clock whenever the fractional
// accumulator carries. Every OS-th os_tick is also flagged as bit_tick.
//
// A new divisor/fraction is written into shadow registers and only becomes
// active at a period boundary. The boundary is the next wrap, a sync pulse,
// or an idle (en=0) cycle. This keeps a single period from mixing the old
// and new divisors.
//
// Parameters
//   N        integer divisor width
//   F        fractional divisor width (fraction unit = 1/2^F clock)
//   OS       oversample ticks per bit (power of two, >= 2)
//   OSW      width of os_cnt, log2(OS)
//   DEF_DIV  divisor loaded at reset
//   DEF_FRAC fraction loaded at reset
//
// Ports
//   clk         in   sole clock, rising edge
//   reset       in   synchronous active-high reset
//   en          in   count enable; low holds the counter and blocks ticks
//   sync        in   one-cycle phase restart (start-bit alignment)
//   cfg_wr      in   one-cycle write strobe for cfg_div / cfg_frac
//   cfg_div     in   [N-1:0] integer part of the oversample period
//   cfg_frac    in   [F-1:0] fractional part of the oversample period
//   os_tick     out  registered one-cycle oversample tick
//   bit_tick    out  registered one-cycle bit tick (every OS-th os_tick)
//   os_cnt      out  [OSW-1:0] current oversample index
//   cfg_pending out  shadow configuration written but not yet active
// ----------------------------------------------------------------------------
module baud_tick_gen #(
   parameter int N        = 16,
   parameter int F        = 4,
   parameter int OS       = 16,
   parameter int OSW      = 4,
   parameter int DEF_DIV  = 32'sd163,
   parameter int DEF_FRAC = 32'sd0
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           en,
   input  logic           sync,
   input  logic           cfg_wr,
   input  logic [N-1:0]   cfg_div,
   input  logic [F-1:0]   cfg_frac,
   output logic           os_tick,
   output logic           bit_tick,
   output logic [OSW-1:0] os_cnt,
   output logic           cfg_pending
);

   localparam logic [N-1:0]   DEF_DIV_V  = DEF_DIV[N-1:0];
   localparam logic [F-1:0]   DEF_FRAC_V = DEF_FRAC[F-1:0];
   localparam logic [N-1:0]   DIV_ONE    = {{(N-1){1'b0}}, 1'b1};
   localparam logic [N:0]     X_ONE      = {{N{1'b0}}, 1'b1};
   localparam logic [OSW-1:0] OS_ONE     = {{(OSW-1){1'b0}}, 1'b1};
   localparam logic [OSW-1:0] OS_LAST    = {OSW{1'b1}};

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [N:0]     x;          // position inside the current period
   logic [F-1:0]   acc;        // fractional accumulator
   logic           ext;        // carry: current period is one clock longer
   logic [N-1:0]   div_r;      // active integer divisor
   logic [F-1:0]   frac_r;     // active fraction
   logic [N-1:0]   div_s;      // shadow integer divisor (register)
   logic [F-1:0]   frac_s;     // shadow fraction (register)

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic [N-1:0]   div_eff_s;
   logic [N:0]     period_s;
   logic [N:0]     last_s;
   logic           wrap_s;
   logic           apply_s;
   logic [F:0]     frac_sum_s;

   logic [N:0]     x_nxt_s;
   logic [F-1:0]   acc_nxt_s;
   logic           ext_nxt_s;
   logic [OSW-1:0] os_cnt_nxt_s;
   logic           os_tick_nxt_s;
   logic           bit_tick_nxt_s;

   logic [N-1:0]   div_r_nxt_s;
   logic [F-1:0]   frac_r_nxt_s;
   logic [N-1:0]   div_s_nxt_s;
   logic [F-1:0]   frac_s_nxt_s;
   logic           pending_nxt_s;

   // Period length and wrap detection for the current period.
   always_comb begin
      // A zero divisor is treated as one so the counter always makes progress.
      if (div_r == {N{1'b0}}) begin
         div_eff_s = DIV_ONE;
      end else begin
         div_eff_s = div_r;
      end
      // One bit wider than the divisor so div + carry can never overflow.
      period_s   = {1'b0, div_eff_s} + {{N{1'b0}}, ext};
      last_s     = period_s - X_ONE;
      // ">=" rather than "==": if the divisor shrinks while idle and x is
      // already past the new end, the period still closes immediately.
      wrap_s     = en & ~sync & (x >= last_s);
      // The wrap that closes a period always uses the fraction of that period.
      frac_sum_s = {1'b0, acc} + {1'b0, frac_r};
      // A pending configuration goes live at any period boundary.
      apply_s    = cfg_pending & (wrap_s | sync | ~en);
   end

   // Next state of the period counter, accumulator, index and tick flags.
   always_comb begin
      x_nxt_s        = x;
      acc_nxt_s      = acc;
      ext_nxt_s      = ext;
      os_cnt_nxt_s   = os_cnt;
      os_tick_nxt_s  = 1'b0;
      bit_tick_nxt_s = 1'b0;
      if (sync) begin
         // Phase restart: discard the partial period, no tick this cycle.
         x_nxt_s      = {(N+1){1'b0}};
         acc_nxt_s    = {F{1'b0}};
         ext_nxt_s    = 1'b0;
         os_cnt_nxt_s = {OSW{1'b0}};
      end else if (!en) begin
         // Idle: everything holds, ticks stay low.
         x_nxt_s      = x;
         os_cnt_nxt_s = os_cnt;
      end else if (wrap_s) begin
         x_nxt_s        = {(N+1){1'b0}};
         acc_nxt_s      = frac_sum_s[F-1:0];
         ext_nxt_s      = frac_sum_s[F];
         os_cnt_nxt_s   = os_cnt + OS_ONE;   // OS is a power of two: natural wrap
         os_tick_nxt_s  = 1'b1;
         bit_tick_nxt_s = (os_cnt == OS_LAST);
      end else begin
         x_nxt_s = x + X_ONE;
      end
   end

   // Next state of the active/shadow configuration and the pending flag.
   always_comb begin
      div_r_nxt_s   = div_r;
      frac_r_nxt_s  = frac_r;
      div_s_nxt_s   = div_s;
      frac_s_nxt_s  = frac_s;
      pending_nxt_s = cfg_pending;
      if (cfg_wr && sync) begin
         // Write coincident with a phase restart: new values are live at once.
         div_r_nxt_s   = cfg_div;
         frac_r_nxt_s  = cfg_frac;
         div_s_nxt_s   = cfg_div;
         frac_s_nxt_s  = cfg_frac;
         pending_nxt_s = 1'b0;
      end else if (apply_s && cfg_wr) begin
         // The older pending write goes live; the new one waits its turn.
         div_r_nxt_s   = div_s;
         frac_r_nxt_s  = frac_s;
         div_s_nxt_s   = cfg_div;
         frac_s_nxt_s  = cfg_frac;
         pending_nxt_s = 1'b1;
      end else if (apply_s) begin
         div_r_nxt_s   = div_s;
         frac_r_nxt_s  = frac_s;
         pending_nxt_s = 1'b0;
      end else if (cfg_wr) begin
         // A repeated write simply overwrites the shadow; last write wins.
         div_s_nxt_s   = cfg_div;
         frac_s_nxt_s  = cfg_frac;
         pending_nxt_s = 1'b1;
      end else begin
         pending_nxt_s = cfg_pending;
      end
   end

   // Period counter, accumulator, oversample index and registered ticks.
   always_ff @(posedge clk) begin
      if (reset) begin
         x        <= {(N+1){1'b0}};
         acc      <= {F{1'b0}};
         ext      <= 1'b0;
         os_cnt   <= {OSW{1'b0}};
         os_tick  <= 1'b0;
         bit_tick <= 1'b0;
      end else begin
         x        <= x_nxt_s;
         acc      <= acc_nxt_s;
         ext      <= ext_nxt_s;
         os_cnt   <= os_cnt_nxt_s;
         os_tick  <= os_tick_nxt_s;
         bit_tick <= bit_tick_nxt_s;
      end
   end

   // Active and shadow divisor registers plus the pending flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_r       <= DEF_DIV_V;
         frac_r      <= DEF_FRAC_V;
         div_s       <= DEF_DIV_V;
         frac_s      <= DEF_FRAC_V;
         cfg_pending <= 1'b0;
      end else begin
         div_r       <= div_r_nxt_s;
         frac_r      <= frac_r_nxt_s;
         div_s       <= div_s_nxt_s;
         frac_s      <= frac_s_nxt_s;
         cfg_pending <= pending_nxt_s;
      end
   end

endmodule

// File: doc/baud_tick_gen.md
BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 Parameter N, default 16: integer-divisor width in bits.
REQ-002 Parameter F, default 4: fractional-divisor width in bits; fraction unit is 1/2^F clock.
REQ-003 Parameter OS, default 16: oversample ticks per bit; power of two, at least 2.
REQ-004 Parameter OSW, default 4: os_cnt width, equal to log2(OS).
REQ-005 Parameter DEF_DIV, default 163: divisor loaded at reset.
REQ-006 Parameter DEF_FRAC, default 0: fraction loaded at reset.
REQ-007 clk  in  1  sole clock; all state updates on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 en  in  1  count enable; when low, the counter holds and no ticks are produced.
REQ-010 sync  in  1  one-cycle pulse that restarts bit phase, used for start-bit alignment.
REQ-011 cfg_wr  in  1  one-cycle strobe that writes cfg_div and cfg_frac.
REQ-012 cfg_div  in  N  integer part of the oversample period, in clocks.
REQ-013 cfg_frac  in  F  fractional part of the oversample period.
REQ-014 os_tick  out  1  registered one-cycle oversample tick.
REQ-015 bit_tick  out  1  registered one-cycle bit tick, coincident with every OS-th os_tick.
REQ-016 os_cnt  out  OSW  current oversample index, 0..OS-1.
REQ-017 cfg_pending  out  1  high while a written configuration is not yet active.

Function
REQ-018 Internal state SHALL be: period counter x (N+1 bits), active div_r/frac_r, shadow div_s/frac_s, accumulator acc (F bits), carry ext, and os_cnt.
REQ-019 Effective divisor SHALL be max(div_r,1), so div_r=0 behaves as 1.
REQ-020 Current period P SHALL be max(div_r,1)+ext, computed without overflow (N+1 bits).
REQ-021 With en=1 and sync=0, x SHALL increment each cycle; when x==P-1 a wrap occurs: x<=0 and os_tick<=1 on the next cycle.
REQ-022 Each wrap SHALL perform {ext,acc} <= acc+frac_r (F+1-bit sum); the new ext sizes the following period.
REQ-023 Each wrap SHALL advance os_cnt modulo OS; bit_tick<=1 on the next cycle iff os_cnt==OS-1 at the wrap.
REQ-024 os_tick and bit_tick SHALL be low in every cycle not immediately following a wrap.
REQ-025 With en=0, x, acc, ext and os_cnt SHALL hold, and os_tick and bit_tick SHALL be 0 on the next cycle.
REQ-026 cfg_wr SHALL load div_s/frac_s and set cfg_pending on the next cycle.
REQ-027 A pending configuration SHALL be copied to div_r/frac_r and cfg_pending cleared at the first wrap, sync, or cycle with en=0, whichever comes first; periods never mix old and new divisors.
REQ-028 At a wrap, the period that follows SHALL use the newly applied div_r; that wrap's acc update SHALL use the old frac_r.
REQ-029 sync=1 SHALL set x, acc, ext and os_cnt to 0 on the next cycle and suppress that cycle's wrap and ticks; sync takes priority over en.
REQ-030 cfg_wr together with sync SHALL make the new configuration active immediately after the sync, with cfg_pending=0.
REQ-031 cfg_wr during a pending state SHALL overwrite the shadow registers; only the last write is applied.
REQ-032 Long-run average oversample period SHALL be max(div,1)+frac/2^F clocks, with no cumulative drift.

Reset
REQ-033 reset SHALL set x=0, acc=0, ext=0, os_cnt=0, os_tick=0, bit_tick=0, and cfg_pending=0.
REQ-034 reset SHALL load div_r=div_s=DEF_DIV and frac_r=frac_s=DEF_FRAC.
REQ-035 reset SHALL take priority over sync, cfg_wr and en.
REQ-036 reset asserted mid-period SHALL discard the partial period and any pending configuration.
REQ-037 After reset release with en=1 and frac_r=0, the first os_tick SHALL occur in cycle max(DEF_DIV,1), counting the first post-reset cycle as 0.

Verification
REQ-038 Case: DEF_DIV=4, frac=0, en=1 -> os_tick in cycles 4, 8, 12, ...; bit_tick only in cycles 64, 128, ...
REQ-039 Case: cfg_div=3, cfg_frac=8 (F=4), applied via sync -> tick intervals 3,3,4,3,4,...; 32 intervals total exactly 112 clocks.
REQ-040 Case: cfg_div=0 -> os_tick every cycle; cfg_div=1 -> same behaviour.
REQ-041 Case: cfg_wr div=10 at x=2 of a div=4 period -> current period ends at 4 clocks, next is 10; cfg_pending high from write+1 until the wrap.
REQ-042 Case: en low for 5 cycles mid-period -> no ticks; the resumed period completes with total active cycles equal to P; sync pulse -> os_cnt=0 and the next tick follows P cycles later.
REQ-043 Case: reset asserted at x=3 with cfg_pending=1 -> all outputs 0 next cycle and DEF_DIV active.
